idu_skid_reg: RTL and testbench

IDU_SKID_REG -- requirements
Module: idu_skid_reg

---
 rtl/idu_skid_reg.sv | 82 ++++++++
 tb/tb_idu_skid_reg.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/idu_skid_reg.sv
// rtl/idu_skid_reg.sv - two-entry skid register between instruction fetch and decode
// Main entry drives the decoder; skid absorbs one extra instruction so ready_o stays registered.
module idu_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode from state only, never from valid_i/ready_i.
  assign valid_o  = (state != EMPTY);
  assign ready_o  = (state != FULL);
  assign count_o  = state;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      araddr_o  <= '0;
      rdata_o   <= '0;
      skid_addr <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            araddr_o <= araddr_i;
            rdata_o  <= rdata_i;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            araddr_o <= araddr_i;
            rdata_o  <= rdata_i;
          end else if (in_fire) begin
            skid_addr <= araddr_i;
            skid_data <= rdata_i;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            araddr_o <= skid_addr;
            rdata_o  <= skid_data;
            state    <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_idu_skid_reg.sv
// tb/tb_idu_skid_reg.sv - directed vector table plus corner sequences and random scoreboard
module tb_idu_skid_reg;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] araddr_i;
  logic [31:0] rdata_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] araddr_o;
  logic [31:0] rdata_o;
  logic [1:0]  count_o;

  int total = 0;
  int passed = 0;

  idu_skid_reg #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .araddr_i(araddr_i), .rdata_i(rdata_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .araddr_o(araddr_o),
    .rdata_o(rdata_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic er, input logic [1:0] ec,
                         input logic [31:0] ea, input logic [31:0] ed);
    chk({tag, ".valid_o"}, 64'(valid_o), 64'(ev));
    chk({tag, ".ready_o"}, 64'(ready_o), 64'(er));
    chk({tag, ".count_o"}, 64'(count_o), 64'(ec));
    chk({tag, ".araddr_o"}, 64'(araddr_o), 64'(ea));
    chk({tag, ".rdata_o"}, 64'(rdata_o), 64'(ed));
  endtask

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        ev;
    logic        er;
    logic [1:0]  ec;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] sb_addr[$];
    logic [31:0] sb_data[$];
    logic        r0;
    logic        in_f;
    logic        out_f;
    logic [31:0] a;
    logic [31:0] d;

    // flush, valid, addr, data, ready -> valid_o, ready_o, count, araddr_o, rdata_o after the edge
    vecs[0]  = '{0, 1, 32'h8000_0000, 32'h0000_0413, 1, 1, 1, 1, 32'h8000_0000, 32'h0000_0413};
    vecs[1]  = '{0, 1, 32'h8000_0004, 32'h0000_0493, 0, 1, 0, 2, 32'h8000_0000, 32'h0000_0413};
    vecs[2]  = '{0, 1, 32'h8000_0008, 32'h0000_0513, 0, 1, 0, 2, 32'h8000_0000, 32'h0000_0413};
    vecs[3]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 1, 32'h8000_0004, 32'h0000_0493};
    vecs[4]  = '{0, 0, 32'h0,         32'h0,         1, 0, 1, 0, 32'h8000_0004, 32'h0000_0493};
    vecs[5]  = '{0, 1, 32'h8000_0010, 32'h0000_1111, 1, 1, 1, 1, 32'h8000_0010, 32'h0000_1111};
    vecs[6]  = '{0, 1, 32'h8000_0014, 32'h0000_2222, 1, 1, 1, 1, 32'h8000_0014, 32'h0000_2222};
    vecs[7]  = '{0, 1, 32'h8000_0018, 32'h0000_3333, 1, 1, 1, 1, 32'h8000_0018, 32'h0000_3333};
    vecs[8]  = '{0, 1, 32'h8000_001C, 32'h0000_4444, 0, 1, 0, 2, 32'h8000_0018, 32'h0000_3333};
    vecs[9]  = '{1, 1, 32'h8000_0020, 32'h0000_5555, 1, 0, 1, 0, 32'h8000_0018, 32'h0000_3333};
    vecs[10] = '{0, 0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h8000_0018, 32'h0000_3333};
    vecs[11] = '{0, 1, 32'h8000_0024, 32'h0000_6666, 0, 1, 1, 1, 32'h8000_0024, 32'h0000_6666};
    vecs[12] = '{0, 0, 32'h0,         32'h0,         0, 1, 1, 1, 32'h8000_0024, 32'h0000_6666};
    vecs[13] = '{1, 0, 32'h0,         32'h0,         0, 0, 1, 0, 32'h8000_0024, 32'h0000_6666};

    rst = 1'b0; valid_i = 0; ready_i = 0; flush_i = 0; araddr_i = '0; rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 1, 0, 32'h0, 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      flush_i = vecs[i].flush; valid_i = vecs[i].valid; araddr_i = vecs[i].addr;
      rdata_i = vecs[i].data;  ready_i = vecs[i].rdy;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ec, vecs[i].ea, vecs[i].ed);
    end

    // Streaming: one instruction per cycle, count stays at 1
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      flush_i = 0; valid_i = 1; ready_i = 1;
      araddr_i = 32'h8000_0000 + 32'(4 * k); rdata_i = 32'hA000_0000 + 32'(k);
      @(posedge clk);
      #1 chk_all($sformatf("stream%0d", k), 1, 1, 1, 32'h8000_0000 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    end

    // Fill to FULL, then assert reset between edges
    @(negedge clk); valid_i = 1; ready_i = 0; araddr_i = 32'h9000_0000; rdata_i = 32'h1;
    @(negedge clk); araddr_i = 32'h9000_0004; rdata_i = 32'h2;
    @(posedge clk); #1 chk("full_before_rst.count_o", 64'(count_o), 64'd2);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", 0, 1, 0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b1; valid_i = 1; ready_i = 0; araddr_i = 32'h9000_0010; rdata_i = 32'h77;
    @(posedge clk); #1 chk_all("after_rst", 1, 1, 1, 32'h9000_0010, 32'h77);
    @(negedge clk); valid_i = 0; flush_i = 1;
    @(posedge clk); #1 chk("flush_clear.count_o", 64'(count_o), 64'd0);

    // Random traffic against an in-order scoreboard
    flush_i = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      a = $urandom; d = $urandom;
      valid_i = ($urandom_range(0, 3) != 0); ready_i = ($urandom_range(0, 2) != 0);
      araddr_i = a; rdata_i = d;
      #1;
      chk("rand.count_o", 64'(count_o), 64'(sb_addr.size()));
      r0 = ready_o;
      ready_i = ~ready_i; #1;
      chk("rand.ready_o_indep", 64'(ready_o), 64'(r0));
      ready_i = ~ready_i; #1;
      in_f = valid_i & ready_o;
      out_f = valid_o & ready_i;
      if (out_f) begin
        if (sb_addr.size() == 0) chk("rand.spurious_valid", 64'(valid_o), 64'd0);
        else begin
          chk("rand.araddr_o", 64'(araddr_o), 64'(sb_addr[0]));
          chk("rand.rdata_o", 64'(rdata_o), 64'(sb_data[0]));
          void'(sb_addr.pop_front());
          void'(sb_data.pop_front());
        end
      end
      if (in_f) begin
        sb_addr.push_back(a);
        sb_data.push_back(d);
      end
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
